// File: rtl/writeback_stage.sv
// Writeback stage: selects the retiring result and drives the register file write port.
// Loads park the stage in WAIT_MEM until data returns or the wait times out.
module writeback_stage #(
  parameter int DATA_W      = 16,
  parameter int REG_AW      = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_dest,
  input  logic              in_reg_write,
  input  logic [1:0]        in_wb_sel,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_link,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  input  logic [REG_AW-1:0] rd_addr1,
  input  logic [REG_AW-1:0] rd_addr2,
  output logic [REG_AW-1:0] write_reg,
  output logic [DATA_W-1:0] write_file,
  output logic              reg_write,
  output logic              hazard1,
  output logic              hazard2,
  output logic              err_timeout
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REG_AW-1:0]  ld_dest_q, ld_dest_d;
  logic               ld_rw_q, ld_rw_d;
  logic [REG_AW-1:0]  write_reg_q, write_reg_d;
  logic [DATA_W-1:0]  write_file_q, write_file_d;
  logic               reg_write_q, reg_write_d;
  logic               err_q, err_d;
  logic [DATA_W-1:0]  sel_data;

  always_comb begin
    sel_data = in_alu;
    case (in_wb_sel)
      2'd2:    sel_data = in_link;
      2'd3:    sel_data = in_imm;
      default: sel_data = in_alu;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ld_dest_d    = ld_dest_q;
    ld_rw_d      = ld_rw_q;
    write_reg_d  = write_reg_q;
    write_file_d = write_file_q;
    reg_write_d  = 1'b0;
    err_d        = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_wb_sel == 2'd1) begin
            ld_dest_d = in_dest;
            ld_rw_d   = in_reg_write;
            cnt_d     = '0;
            state_d   = WAIT_MEM;
          end else begin
            write_reg_d  = in_dest;
            write_file_d = sel_data;
            reg_write_d  = in_reg_write;
          end
        end
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          write_reg_d  = ld_dest_q;
          write_file_d = mem_rdata;
          reg_write_d  = ld_rw_q;
          state_d      = IDLE;
        end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          // This cycle is the MEM_TIMEOUT-th without data: abandon the load.
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ld_dest_q    <= '0;
      ld_rw_q      <= 1'b0;
      write_reg_q  <= '0;
      write_file_q <= '0;
      reg_write_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ld_dest_q    <= ld_dest_d;
      ld_rw_q      <= ld_rw_d;
      write_reg_q  <= write_reg_d;
      write_file_q <= write_file_d;
      reg_write_q  <= reg_write_d;
      err_q        <= err_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign hazard1     = (state_q == WAIT_MEM) && ld_rw_q && (rd_addr1 == ld_dest_q);
  assign hazard2     = (state_q == WAIT_MEM) && ld_rw_q && (rd_addr2 == ld_dest_q);
  assign write_reg   = write_reg_q;
  assign write_file  = write_file_q;
  assign reg_write   = reg_write_q;
  assign err_timeout = err_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: table of non-load ops plus load, timeout and reset sequences,
// with expected register writes queued at drive time and checked when reg_write appears.
module tb_writeback_stage;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, in_reg_write, mem_rvalid;
  logic [2:0]  in_dest, rd_addr1, rd_addr2, write_reg;
  logic [1:0]  in_wb_sel;
  logic [15:0] in_alu, in_link, in_imm, mem_rdata, write_file;
  logic        reg_write, hazard1, hazard2, err_timeout;

  writeback_stage #(.DATA_W(16), .REG_AW(3), .MEM_TIMEOUT(15)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_dest(in_dest), .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
    .in_alu(in_alu), .in_link(in_link), .in_imm(in_imm),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .write_reg(write_reg), .write_file(write_file), .reg_write(reg_write),
    .hazard1(hazard1), .hazard2(hazard2), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  dest;
    logic        rw;
    logic [15:0] alu, link, imm, exp;
  } vec_t;

  typedef struct {
    logic [2:0]  r;
    logic [15:0] d;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs of the previous posedge are sampled at the negedge.
  task automatic mon();
    logic e;
    exp_t x;
    e = (sb.size() != 0);
    chk("reg_write", {31'd0, reg_write}, {31'd0, e});
    if (reg_write && e) begin
      x = sb.pop_front();
      chk("write_reg", {29'd0, write_reg}, {29'd0, x.r});
      chk("write_file", {16'd0, write_file}, {16'd0, x.d});
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    mon();
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_reg_write = 1'b0; in_wb_sel = 2'd0; in_dest = 3'd0;
    in_alu = 16'd0; in_link = 16'd0; in_imm = 16'd0;
    mem_rvalid = 1'b0; mem_rdata = 16'd0;
  endtask

  task automatic drive_load(input logic [2:0] dest);
    in_valid = 1'b1; in_wb_sel = 2'd1; in_dest = dest; in_reg_write = 1'b1;
  endtask

  initial begin
    vecs[0] = '{sel: 2'd0, dest: 3'd3, rw: 1'b1, alu: 16'h1234, link: 16'h0000, imm: 16'h0000, exp: 16'h1234};
    vecs[1] = '{sel: 2'd2, dest: 3'd1, rw: 1'b1, alu: 16'hAAAA, link: 16'h0042, imm: 16'h5555, exp: 16'h0042};
    vecs[2] = '{sel: 2'd3, dest: 3'd7, rw: 1'b1, alu: 16'h1111, link: 16'h2222, imm: 16'hFFF0, exp: 16'hFFF0};
    vecs[3] = '{sel: 2'd0, dest: 3'd0, rw: 1'b1, alu: 16'hBEEF, link: 16'h3333, imm: 16'h4444, exp: 16'hBEEF};
    vecs[4] = '{sel: 2'd0, dest: 3'd4, rw: 1'b0, alu: 16'h7777, link: 16'h0001, imm: 16'h0002, exp: 16'h7777};
    vecs[5] = '{sel: 2'd2, dest: 3'd5, rw: 1'b1, alu: 16'h0000, link: 16'h00C8, imm: 16'h0001, exp: 16'h00C8};

    reset_n = 1'b0;
    idle_inputs();
    rd_addr1 = 3'd0; rd_addr2 = 3'd0;
    #3;
    chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
    chk("rst_write_file", {16'd0, write_file}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Back-to-back non-load ops, including r0 and a no-write op.
    foreach (vecs[i]) begin
      in_valid = 1'b1; in_wb_sel = vecs[i].sel; in_dest = vecs[i].dest;
      in_reg_write = vecs[i].rw; in_alu = vecs[i].alu; in_link = vecs[i].link; in_imm = vecs[i].imm;
      #1 chk("vec_in_ready", {31'd0, in_ready}, 32'd1);
      if (vecs[i].rw) sb.push_back('{r: vecs[i].dest, d: vecs[i].exp});
      tick();
    end
    idle_inputs();
    tick();

    // Load to r2, data three cycles after accept; rvalid in accept cycle ignored.
    drive_load(3'd2);
    mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
    rd_addr1 = 3'd2; rd_addr2 = 3'd4;
    tick();
    idle_inputs();
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) rd_addr2 = 3'd2;
      if (c == 3) begin
        mem_rvalid = 1'b1; mem_rdata = 16'h00FF;
        sb.push_back('{r: 3'd2, d: 16'h00FF});
      end
      #1;
      chk("ld_in_ready", {31'd0, in_ready}, 32'd0);
      chk("ld_hazard1", {31'd0, hazard1}, 32'd1);
      chk("ld_hazard2", {31'd0, hazard2}, (c >= 2) ? 32'd1 : 32'd0);
      tick();
    end
    idle_inputs();
    #1;
    chk("ld_done_ready", {31'd0, in_ready}, 32'd1);
    chk("ld_done_hazard1", {31'd0, hazard1}, 32'd0);
    chk("ld_done_hazard2", {31'd0, hazard2}, 32'd0);

    // Load that never gets data.
    drive_load(3'd5);
    rd_addr1 = 3'd5;
    tick();
    idle_inputs();
    for (int c = 1; c <= 15; c++) begin
      #1;
      chk("to_in_ready", {31'd0, in_ready}, 32'd0);
      chk("to_err_pending", {31'd0, err_timeout}, 32'd0);
      tick();
    end
    #1;
    chk("to_err", {31'd0, err_timeout}, 32'd1);
    chk("to_ready", {31'd0, in_ready}, 32'd1);
    chk("to_hazard1", {31'd0, hazard1}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 16'h5A5A;
    tick();
    mem_rvalid = 1'b0;
    chk("to_err_sticky", {31'd0, err_timeout}, 32'd1);

    // Reset while a load is outstanding.
    drive_load(3'd6);
    tick();
    idle_inputs();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_reg_write", {31'd0, reg_write}, 32'd0);
    chk("arst_write_reg", {29'd0, write_reg}, 32'd0);
    chk("arst_write_file", {16'd0, write_file}, 32'd0);
    chk("arst_err", {31'd0, err_timeout}, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    rd_addr1 = 3'd6;
    mem_rvalid = 1'b1; mem_rdata = 16'h0BAD;
    #1 chk("arst_hazard1", {31'd0, hazard1}, 32'd0);
    tick();
    idle_inputs();
    tick();
    chk("arst_err_after", {31'd0, err_timeout}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
